trigger_sequence_generator: RTL
===============================

// Module: trigger_sequence_generator
// PURPOSE
//  Transmit-side counterpart of the trigger sequencer: emits a programmed sequence of trigger pulses
//  on per-slot lanes with programmed edge-to-edge delays. Drives target/glitch lines or loops back
//  into the sequencer for self-test. Sits in the adc_clk domain beside the trigger logic, set by registers.
// PARAMETERS
//  pNUM_TRIGGERS   4   number of output lanes/slots (2..16)
//  pCOUNTER_WIDTH  16  width of each inter-pulse delay and of the delay counter
//  pWIDTH_BITS     8   width of the pulse-width setting
// PORTS
//  adc_clk          in   1                          sole clock, all logic rising-edge
//  reset_n          in   1                          asynchronous, active-low reset
//  I_start          in   1                          start request, sampled in IDLE only
//  I_abort          in   1                          terminate sequence immediately
//  I_delay          in   (pNUM_TRIGGERS-1)*W        delay[i] = cycles from lane i rise to lane i+1 rise
//  I_pulse_width    in   pWIDTH_BITS                high cycles per pulse
//  I_last_trigger   in   4                          index of final slot
//  O_trigger        out  pNUM_TRIGGERS              registered pulse lanes
//  O_busy           out  1                          high whenever state != IDLE
//  O_done           out  1                          one-cycle pulse on normal completion
// BEHAVIOUR
//  - Reset: state IDLE, O_trigger=0, O_busy=0, O_done=0, counters/slot=0.
//  - States: IDLE -> RUN -> DONE -> IDLE. DONE lasts exactly one cycle (O_done=1 there).
//  - IDLE: I_start=1 latches I_delay, I_pulse_width, I_last_trigger into shadow regs; slot=0,
//    counter=0; next cycle O_trigger[0]=1 (latency 1 cycle from I_start sample).
//  - Shadow regs are used for the whole sequence; input changes mid-sequence have no effect.
//  - RUN: counter increments every cycle from 0 on the rise cycle of the current slot's pulse.
//    Lane[slot] high while counter < width_eff; width_eff = max(I_pulse_width,1).
//    When slot != last and counter == delay_eff[slot] - 1: next cycle slot+1 rises, counter=0,
//    lane[slot] forced low (pulse truncated if width_eff > delay_eff). delay_eff = max(delay,1).
//  - Last slot: after width_eff high cycles, -> DONE; O_trigger all low in DONE.
//  - At most one lane high in any cycle; O_trigger is a register, never combinational.
//  - last_eff = min(I_last_trigger, pNUM_TRIGGERS-1); last_eff=0 gives a single pulse on lane 0.
//  - I_start while not IDLE: ignored (no restart, no queueing).
//  - I_abort (any non-IDLE state): next cycle IDLE, all lanes low, O_done not asserted.
//    I_abort and I_start together in IDLE: abort wins, stays IDLE.
//  - Counter never wraps: delay_eff <= 2^W-1 guarantees terminal match before overflow.
//  - reset_n low mid-sequence: outputs low asynchronously, no O_done.
// CONFIGURATION
//  - Macro TRIGGER_SEQ_REPEAT_EN:
//    defined: adds ports I_repeat (in, 8) and I_repeat_gap (in, W), latched at start. After the
//      last slot's rise, when counter == max(I_repeat_gap,1)-1, restart at slot 0 instead of DONE;
//      total passes = I_repeat+1; O_done only after the final pass; O_busy stays high between
//      passes. Last-slot pulse truncated by gap as for delays.
//    not defined: ports absent; exactly one pass per I_start.
// STRUCTURE
//  - Shared include trigger_seq_defines.vh: state encodings (pS_IDLE, pS_RUN, pS_DONE), slot-index
//    width function (same mapping as the sequencer: 2->1, <=4->2, <=8->3, <=16->4).
//  - One sub-module: trig_seq_delay_counter (load/clear, increment, terminal-match compare against
//    a selected threshold, outputs match and below-width flags). FSM, shadow regs, lane decode top-level.
// TESTING
//  - N=4, delays {10,20,5}, width 3, last=3, start -> lane rises at t=1,11,31,36; each high 3
//    cycles; O_done at t=39; O_busy t=1..39.
//  - delays {2,2,2}, width 5 -> each pulse truncated to 2 cycles, never two lanes high at once.
//  - delay {0,..}, width 0, last=1 -> treated as 1: lane0 high t=1, lane1 high t=2, O_done t=3.
//  - last=9 with N=4 -> clamped to 3; I_start pulsed mid-sequence -> ignored, timing unchanged.
//  - abort at t=15 in first test -> all lanes low t=16, O_busy=0, no O_done; reset_n low at
//    t=12 -> lanes low immediately.
//  - REPEAT_EN: repeat=2, gap=8, delays {4,4,4}, width 1 -> lane0 rises t=1,21,41; O_done t=54.
//  - Loopback: output drives trigger_sequencer with min/max windows bracketing delays ->
//    sequencer asserts O_trigger once; delay outside window -> no trigger.

Source files
------------

// File: rtl/trigger_sequence_generator_pkg.sv
// Shared definitions for the trigger sequence generator: FSM state encoding
// and the slot-index width mapping used by the trigger sequencer family.
package trigger_sequence_generator_pkg;

    typedef enum logic [1:0] {
        pS_IDLE = 2'd0,
        pS_RUN  = 2'd1,
        pS_DONE = 2'd2
    } seq_state_t;

    // Bits needed to index a slot: 2->1, <=4->2, <=8->3, <=16->4.
    function automatic int slot_index_width(input int num_slots);
        if (num_slots <= 2) return 1;
        if (num_slots <= 4) return 2;
        if (num_slots <= 8) return 3;
        return 4;
    endfunction

endpackage

// File: rtl/trigger_sequence_generator_delay_counter.sv
// Edge-to-edge delay counter. Counts up from zero on the rise cycle of the
// current pulse, flags the terminal cycle (count == threshold-1) and whether
// the pulse should still be high on the following cycle.
module trigger_sequence_generator_delay_counter #(
    parameter int pCOUNTER_WIDTH = 16
) (
    input  logic                      adc_clk,
    input  logic                      reset_n,
    input  logic                      i_clear,
    input  logic [pCOUNTER_WIDTH-1:0] i_threshold,
    input  logic [pCOUNTER_WIDTH-1:0] i_width,
    output logic                      o_match,
    output logic                      o_next_below
);

    localparam int W = pCOUNTER_WIDTH;

    logic [W-1:0] r_count;

    // Counter restarts at zero whenever the owner clears it, else increments.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    // Threshold is always >= 1, so threshold-1 never underflows.
    assign o_match      = (r_count == (i_threshold - W'(1)));
    assign o_next_below = (({1'b0, r_count} + (W+1)'(1)) < {1'b0, i_width});

endmodule

// File: rtl/trigger_sequence_generator.sv
// Trigger sequence generator: emits a programmed train of pulses, one per
// lane, with programmed rise-to-rise delays. All settings are shadowed at
// start so register writes mid-sequence have no effect.
// Optional feature macro: TRIGGER_SEQ_REPEAT_EN (repeat passes with a gap).
//
// state   | meaning
// IDLE    | waiting for I_start, all lanes low
// RUN     | emitting pulses, counter tracks cycles since current rise
// DONE    | one-cycle completion strobe on O_done
module trigger_sequence_generator
    import trigger_sequence_generator_pkg::*;
#(
    parameter int pNUM_TRIGGERS  = 4,
    parameter int pCOUNTER_WIDTH = 16,
    parameter int pWIDTH_BITS    = 8
) (
    input  logic                                      adc_clk,
    input  logic                                      reset_n,
    input  logic                                      I_start,
    input  logic                                      I_abort,
    input  logic [(pNUM_TRIGGERS-1)*pCOUNTER_WIDTH-1:0] I_delay,
    input  logic [pWIDTH_BITS-1:0]                    I_pulse_width,
    input  logic [3:0]                                I_last_trigger,
`ifdef TRIGGER_SEQ_REPEAT_EN
    input  logic [7:0]                                I_repeat,
    input  logic [pCOUNTER_WIDTH-1:0]                 I_repeat_gap,
`endif
    output logic [pNUM_TRIGGERS-1:0]                  O_trigger,
    output logic                                      O_busy,
    output logic                                      O_done
);

    localparam int W     = pCOUNTER_WIDTH;
    localparam int SW    = slot_index_width(pNUM_TRIGGERS);
    localparam int NSLOT = 1 << SW;
    localparam logic [3:0] LAST_MAX = 4'(pNUM_TRIGGERS - 1);
    localparam logic [pNUM_TRIGGERS-1:0] LANE0 = pNUM_TRIGGERS'(1);

    seq_state_t               r_state;
    logic [3:0]               r_slot;
    logic [3:0]               r_last;
    logic [pWIDTH_BITS-1:0]   r_width_eff;
    logic [W-1:0]             r_delay_eff [NSLOT];
    logic [pNUM_TRIGGERS-1:0] r_trig;
    logic                     r_busy;
    logic                     r_done;

    logic [W-1:0]             w_delay_in [NSLOT];
    logic [3:0]               w_last_in;
    logic [pWIDTH_BITS-1:0]   w_width_in;
    logic [W-1:0]             w_threshold;
    logic [W-1:0]             w_gap_eff;
    logic                     w_more_passes;
    logic                     w_match;
    logic                     w_next_below;
    logic                     w_cnt_clear;

    // Zero delays behave as one cycle; unused index slots pad with 1.
    for (genvar g = 0; g < NSLOT; g++) begin : g_delay
        if (g < pNUM_TRIGGERS - 1) begin : g_used
            assign w_delay_in[g] = (I_delay[g*W +: W] == '0) ? W'(1) : I_delay[g*W +: W];
        end else begin : g_pad
            assign w_delay_in[g] = W'(1);
        end
    end

    assign w_last_in  = (I_last_trigger > LAST_MAX) ? LAST_MAX : I_last_trigger;
    assign w_width_in = (I_pulse_width == '0) ? pWIDTH_BITS'(1) : I_pulse_width;

`ifdef TRIGGER_SEQ_REPEAT_EN
    logic [7:0]   r_passes_left;
    logic [W-1:0] r_gap_eff;

    // Remaining passes and the last-rise-to-restart gap, latched at start.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_passes_left <= '0;
            r_gap_eff     <= '0;
        end else if (r_state == pS_IDLE && I_start && !I_abort) begin
            r_passes_left <= I_repeat;
            r_gap_eff     <= (I_repeat_gap == '0) ? W'(1) : I_repeat_gap;
        end else if (r_state == pS_RUN && !I_abort && w_match && r_slot == r_last
                     && w_more_passes) begin
            r_passes_left <= r_passes_left - 8'd1;
        end
    end

    assign w_more_passes = (r_passes_left != '0);
    assign w_gap_eff     = r_gap_eff;
`else
    assign w_more_passes = 1'b0;
    assign w_gap_eff     = W'(1);
`endif

    // Terminal threshold: next-lane delay, restart gap, or final pulse width.
    always_comb begin
        w_threshold = W'(r_width_eff);
        if (r_slot != r_last) begin
            w_threshold = r_delay_eff[r_slot[SW-1:0]];
        end else if (w_more_passes) begin
            w_threshold = w_gap_eff;
        end
    end

    assign w_cnt_clear = (r_state != pS_RUN) || I_abort || w_match;

    trigger_sequence_generator_delay_counter #(
        .pCOUNTER_WIDTH (W)
    ) u_delay_counter (
        .adc_clk      (adc_clk),
        .reset_n      (reset_n),
        .i_clear      (w_cnt_clear),
        .i_threshold  (w_threshold),
        .i_width      (W'(r_width_eff)),
        .o_match      (w_match),
        .o_next_below (w_next_below)
    );

    // Sequencing FSM; lane outputs are computed for the coming cycle and registered.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= pS_IDLE;
            r_slot      <= '0;
            r_last      <= '0;
            r_width_eff <= '0;
            for (int i = 0; i < NSLOT; i++) r_delay_eff[i] <= '0;
            r_trig      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                pS_IDLE: begin
                    if (I_start && !I_abort) begin
                        r_delay_eff <= w_delay_in;
                        r_width_eff <= w_width_in;
                        r_last      <= w_last_in;
                        r_slot      <= '0;
                        r_trig      <= LANE0;
                        r_busy      <= 1'b1;
                        r_state     <= pS_RUN;
                    end
                end
                pS_RUN: begin
                    if (I_abort) begin
                        r_trig  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= pS_IDLE;
                    end else if (w_match) begin
                        if (r_slot != r_last) begin
                            r_slot <= r_slot + 4'd1;
                            r_trig <= LANE0 << (r_slot + 4'd1);
                        end else if (w_more_passes) begin
                            r_slot <= '0;
                            r_trig <= LANE0;
                        end else begin
                            r_trig  <= '0;
                            r_done  <= 1'b1;
                            r_state <= pS_DONE;
                        end
                    end else begin
                        r_trig <= w_next_below ? (LANE0 << r_slot) : '0;
                    end
                end
                pS_DONE: begin
                    r_trig  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= pS_IDLE;
                end
                default: begin
                    r_trig  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= pS_IDLE;
                end
            endcase
        end
    end

    assign O_trigger = r_trig;
    assign O_busy    = r_busy;
    assign O_done    = r_done;

endmodule
